// File: rtl/if_stage_pkg.sv
// Types and defaults shared by the instruction-fetch stage and its fetch buffer.
package if_stage_pkg;

   localparam int unsigned IF_FIFO_DEPTH = 4;
   localparam int unsigned IF_MAX_OUTST  = 2;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } if_id_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage : if_stage_pkg

// File: rtl/riscv_pkg.sv
// Shared RISC-V ISA constants used across the pipeline.
package riscv;

   localparam logic [31:0] I_NOP = 32'h0000_0013;  // addi x0, x0, 0

endpackage : riscv

// File: rtl/if_stage_fetch_fifo.sv
// Synchronous fetch buffer holding {instr, pc} entries; flush empties it in one cycle.
module fetch_fifo
   import if_stage_pkg::*;
#(
   parameter  int unsigned DEPTH = IF_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  if_id_t           push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output if_id_t           head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   if_id_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full_o | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; an entry is only ever read after count says it was written.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule : fetch_fifo

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests, stale-response
// dropping after redirects, and a fetch buffer feeding decode.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH,
   parameter int unsigned MAX_OUTST  = IF_MAX_OUTST
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
   localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [31:0]    resp_pc_q,  resp_pc_d;
   logic [CW-1:0]  outst_q,    outst_d;
   logic [CW-1:0]  drop_q,     drop_d;

   logic           gnt_fire;
   logic           rsp_ok;
   logic           credit_ok;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_flush;
   if_id_t         fifo_head;
   logic [FCW-1:0] fifo_count;
   logic           fifo_full;
   logic           fifo_empty;

   // A request is only issued if its response is guaranteed a buffer slot.
   assign credit_ok   = (32'(outst_q) + 32'(fifo_count) < 32'(FIFO_DEPTH))
                      & (32'(outst_q) < 32'(MAX_OUTST));
   assign imem_req_o  = ~rst & ~redirect_i & credit_ok;
   assign imem_addr_o = fetch_pc_q;
   assign gnt_fire    = imem_req_o & imem_gnt_i;
   assign rsp_ok      = imem_rvalid_i & (outst_q != '0);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      outst_d    = outst_q + CW'(gnt_fire) - CW'(rsp_ok);
      if (redirect_i) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = word_align(redirect_pc_i);
         resp_pc_d  = word_align(redirect_pc_i);
         drop_d     = outst_d;
         fifo_flush = 1'b1;
      end else begin
         if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_ok) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               fifo_push = 1'b1;
               resp_pc_d = resp_pc_q + 32'd4;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= word_align(RESET_PC);
         resp_pc_q  <= word_align(RESET_PC);
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   assign fifo_pop = valid_o & ready_i & ~redirect_i;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i ('{instr: imem_rdata_i, pc: resp_pc_q}),
      .pop_i       (fifo_pop),
      .flush_i     (fifo_flush),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign valid_o = ~fifo_empty;
   assign instr_o = valid_o ? fifo_head.instr : riscv::I_NOP;
   assign pc_o    = valid_o ? fifo_head.pc    : 32'h0;

   a_no_spurious_rvalid : assert property (@(posedge clk) disable iff (rst)
      imem_rvalid_i |-> (outst_q != '0));
   a_push_has_room : assert property (@(posedge clk) disable iff (rst)
      fifo_push |-> ~fifo_full);
   a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
      drop_q <= outst_q);

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a queue-based model of the imem and decode streams.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        ready_i;

   if_stage #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH),
      .MAX_OUTST  (MAXO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: imem requests in flight (tagged with the path epoch) and words owed to decode.
   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } pend_t;

   pend_t       pend[$];
   if_id_t      kept[$];
   logic [31:0] exp_fetch_pc;
   int          epoch = 0;
   int          cyc   = 0;

   int          p_gnt, p_ready, p_rvalid, p_redir, p_rst, lat_min, lat_max;
   bit          use_fixed_pc;
   logic [31:0] fixed_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'h5a5a_0000;
   endfunction

   task automatic set_knobs(input int g, input int r, input int v, input int d, input int s,
                            input int lmin, input int lmax);
      p_gnt = g; p_ready = r; p_rvalid = v; p_redir = d; p_rst = s;
      lat_min = lmin; lat_max = lmax;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         logic        exp_req;
         logic        do_pop;
         logic [31:0] rpc;
         @(negedge clk);
         rst        = ($urandom_range(99) < p_rst);
         imem_gnt_i = ($urandom_range(99) < p_gnt);
         ready_i    = ($urandom_range(99) < p_ready);
         redirect_i = !rst && ($urandom_range(99) < p_redir);
         rpc        = $urandom;
         if ($urandom_range(3) == 0) rpc = {30'h3fff_fffd, rpc[1:0]};
         redirect_pc_i = use_fixed_pc ? fixed_pc : rpc;
         if (!rst && pend.size() > 0 && cyc >= pend[0].due && $urandom_range(99) < p_rvalid) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0].addr);
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
         end
         #1;
         exp_req = !rst && !redirect_i && (pend.size() + kept.size() < DEPTH) && (pend.size() < MAXO);
         check("imem_req", imem_req_o, exp_req);
         if (imem_req_o) check("imem_addr", imem_addr_o, exp_fetch_pc);
         check("valid", valid_o, kept.size() > 0);
         if (kept.size() > 0) begin
            check("pc", pc_o, kept[0].pc);
            check("instr", instr_o, mem_word(kept[0].pc));
         end else begin
            check("idle_instr", instr_o, NOP);
            check("idle_pc", pc_o, 32'h0);
         end

         // Apply what the coming clock edge does to the model.
         do_pop = (kept.size() > 0) && ready_i && !redirect_i;
         if (rst) begin
            pend.delete();
            kept.delete();
            exp_fetch_pc = RESET_PC;
            epoch++;
         end else begin
            if (do_pop) void'(kept.pop_front());
            if (imem_rvalid_i) begin
               pend_t h;
               h = pend.pop_front();
               if (!redirect_i && h.epoch == epoch) kept.push_back('{instr: imem_rdata_i, pc: h.addr});
            end
            if (redirect_i) begin
               kept.delete();
               epoch++;
               exp_fetch_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (exp_req && imem_gnt_i) begin
               pend.push_back('{addr: exp_fetch_pc, epoch: epoch,
                                due: cyc + int'($urandom_range(lat_max, lat_min))});
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
         end
         cyc++;
      end
   endtask

   initial begin
      rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
      use_fixed_pc = 1'b0; fixed_pc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid_o, 1'b0);
      check("rst_instr", instr_o, NOP);
      check("rst_pc", pc_o, 32'h0);
      check("rst_req", imem_req_o, 1'b0);
      exp_fetch_pc = RESET_PC;

      // Streaming with immediate grants and 1-cycle responses.
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      run_cycles(30);
      // Decode stalls: buffer fills, requests stop, then drain in order.
      set_knobs(100, 0, 100, 0, 0, 1, 1);
      run_cycles(10);
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      run_cycles(15);
      // Grant withheld: address must hold.
      set_knobs(0, 100, 100, 0, 0, 1, 1);
      run_cycles(3);
      set_knobs(100, 100, 100, 0, 0, 1, 1);
      run_cycles(5);
      // Slow memory, then a redirect to 0x100 with responses in flight.
      set_knobs(100, 100, 100, 0, 0, 3, 3);
      run_cycles(6);
      use_fixed_pc = 1'b1; fixed_pc = 32'h0000_0100;
      set_knobs(100, 100, 100, 100, 0, 3, 3);
      run_cycles(1);
      use_fixed_pc = 1'b0;
      set_knobs(100, 100, 100, 0, 0, 3, 3);
      run_cycles(15);
      // Back-to-back redirects.
      set_knobs(80, 80, 80, 50, 0, 1, 2);
      run_cycles(100);
      // Fully random traffic including mid-stream resets.
      set_knobs(70, 70, 70, 5, 2, 1, 4);
      run_cycles(3000);
      set_knobs(90, 90, 90, 2, 0, 1, 1);
      run_cycles(500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_if_stage
